// File: rtl/writeback_queue.sv
// Register-file writeback queue: buffers ALU and load results in order and drains one write per cycle.
// Optional forwarding lookup is built only when WB_FORWARD_EN is defined; otherwise the lookup outputs are tied to 0.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clk_In,
    input  logic              Rst_In,
    input  logic              ALU_Valid_In,
    output logic              ALU_Ready_Out,
    input  logic [ADDR_W-1:0] ALU_RD_Addr_In,
    input  logic [DATA_W-1:0] ALU_RD_Data_In,
    input  logic              Load_Valid_In,
    output logic              Load_Ready_Out,
    input  logic [ADDR_W-1:0] Load_RD_Addr_In,
    input  logic [DATA_W-1:0] Load_RD_Data_In,
    output logic              Reg_Write_flag_Out,
    output logic [ADDR_W-1:0] RD_Addr_Out,
    output logic [DATA_W-1:0] RD_Data_Out,
    input  logic [ADDR_W-1:0] RS1_Addr_In,
    input  logic [ADDR_W-1:0] RS2_Addr_In,
    output logic              RS1_Hit_Out,
    output logic [DATA_W-1:0] RS1_Data_Out,
    output logic              RS2_Hit_Out,
    output logic [DATA_W-1:0] RS2_Data_Out,
    output logic              Busy_Out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] load_slot;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic alu_fire;
    logic load_fire;
    logic alu_push;
    logic load_push;
    logic pop;

    // Ready depends only on the registered count, so a same-cycle pop never opens a slot.
    assign ALU_Ready_Out  = (count < DEPTH_C);
    assign alu_fire       = ALU_Valid_In & ALU_Ready_Out;
    assign Load_Ready_Out = ((count + CNT_W'(alu_fire)) < DEPTH_C);
    assign load_fire      = Load_Valid_In & Load_Ready_Out;

    // Writes to register 0 complete the handshake but are dropped here.
    assign alu_push  = alu_fire & (ALU_RD_Addr_In != '0);
    assign load_push = load_fire & (Load_RD_Addr_In != '0);
    assign pop       = (count != '0);

    assign load_slot  = wr_ptr + PTR_W'(alu_push);
    assign count_next = count + CNT_W'(alu_push) + CNT_W'(load_push) - CNT_W'(pop);

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(alu_push) + PTR_W'(load_push);
        end
    end

    // ALU result is older than a same-edge load, so it takes the lower slot.
    always_ff @(posedge Clk_In) begin
        if (alu_push) begin
            mem_addr[wr_ptr] <= ALU_RD_Addr_In;
            mem_data[wr_ptr] <= ALU_RD_Data_In;
        end
        if (load_push) begin
            mem_addr[load_slot] <= Load_RD_Addr_In;
            mem_data[load_slot] <= Load_RD_Data_In;
        end
    end

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            Reg_Write_flag_Out <= 1'b0;
            RD_Addr_Out        <= '0;
            RD_Data_Out        <= '0;
        end else if (pop) begin
            Reg_Write_flag_Out <= 1'b1;
            RD_Addr_Out        <= mem_addr[rd_ptr];
            RD_Data_Out        <= mem_data[rd_ptr];
        end else begin
            Reg_Write_flag_Out <= 1'b0;
        end
    end

    assign Busy_Out = (count != '0) | Reg_Write_flag_Out;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Scan oldest to newest so a later match overrides; the output register is oldest of all.
    always_comb begin
        RS1_Hit_Out  = 1'b0;
        RS1_Data_Out = '0;
        RS2_Hit_Out  = 1'b0;
        RS2_Data_Out = '0;
        idx          = rd_ptr;
        if (Reg_Write_flag_Out) begin
            if ((RS1_Addr_In != '0) && (RD_Addr_Out == RS1_Addr_In)) begin
                RS1_Hit_Out  = 1'b1;
                RS1_Data_Out = RD_Data_Out;
            end
            if ((RS2_Addr_In != '0) && (RD_Addr_Out == RS2_Addr_In)) begin
                RS2_Hit_Out  = 1'b1;
                RS2_Data_Out = RD_Data_Out;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((RS1_Addr_In != '0) && (mem_addr[idx] == RS1_Addr_In)) begin
                    RS1_Hit_Out  = 1'b1;
                    RS1_Data_Out = mem_data[idx];
                end
                if ((RS2_Addr_In != '0) && (mem_addr[idx] == RS2_Addr_In)) begin
                    RS2_Hit_Out  = 1'b1;
                    RS2_Data_Out = mem_data[idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{RS1_Addr_In, RS2_Addr_In};
    assign RS1_Hit_Out   = 1'b0;
    assign RS1_Data_Out  = '0;
    assign RS2_Hit_Out   = 1'b0;
    assign RS2_Data_Out  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH=4, ADDR_W=5, DATA_W=32).
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        wr_flag;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_hit;
    logic [31:0] rs1_data;
    logic        rs2_hit;
    logic [31:0] rs2_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .Clk_In(clk),
        .Rst_In(rst),
        .ALU_Valid_In(alu_valid),
        .ALU_Ready_Out(alu_ready),
        .ALU_RD_Addr_In(alu_addr),
        .ALU_RD_Data_In(alu_data),
        .Load_Valid_In(load_valid),
        .Load_Ready_Out(load_ready),
        .Load_RD_Addr_In(load_addr),
        .Load_RD_Data_In(load_data),
        .Reg_Write_flag_Out(wr_flag),
        .RD_Addr_Out(rd_addr),
        .RD_Data_Out(rd_data),
        .RS1_Addr_In(rs1_addr),
        .RS2_Addr_In(rs2_addr),
        .RS1_Hit_Out(rs1_hit),
        .RS1_Data_Out(rs1_data),
        .RS2_Hit_Out(rs2_hit),
        .RS2_Data_Out(rs2_data),
        .Busy_Out(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        alu_addr   = '0;
        alu_data   = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
    endtask

    task automatic drive_load(input logic [4:0] a, input logic [31:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rs1_addr = '0;
        rs2_addr = '0;
        @(negedge clk);
        @(negedge clk);
        total++; if (wr_flag !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_outputs got flag=%b addr=%0d data=%h want 0/0/0", wr_flag, rd_addr, rd_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        drive_alu(5'd5, 32'hDEADBEEF);
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alu_ready got %b want 1", alu_ready); end
        @(negedge clk);
        idle_inputs();
        total++; if (wr_flag !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL first_push got flag=%b busy=%b want 0/1", wr_flag, busy); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL first_write got flag=%b addr=%0d data=%h want 1/5/deadbeef", wr_flag, rd_addr, rd_data); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF || busy !== 1'b0) begin bad++; $display("[TB] FAIL first_hold got flag=%b addr=%0d data=%h busy=%b want 0/5/deadbeef/0", wr_flag, rd_addr, rd_data, busy); end
    endtask

    task automatic test_dual_push();
        drive_alu(5'd3, 32'h11);
        drive_load(5'd4, 32'h22);
        #1;
        total++; if (alu_ready !== 1'b1 || load_ready !== 1'b1) begin bad++; $display("[TB] FAIL dual_ready got alu=%b load=%b want 1/1", alu_ready, load_ready); end
        @(negedge clk);
        idle_inputs();
        total++; if (wr_flag !== 1'b0) begin bad++; $display("[TB] FAIL dual_latency got flag=%b want 0", wr_flag); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h11) begin bad++; $display("[TB] FAIL dual_first got flag=%b addr=%0d data=%h want 1/3/11", wr_flag, rd_addr, rd_data); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h22) begin bad++; $display("[TB] FAIL dual_second got flag=%b addr=%0d data=%h want 1/4/22", wr_flag, rd_addr, rd_data); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL dual_idle got flag=%b busy=%b want 0/0", wr_flag, busy); end
    endtask

    task automatic test_back_to_back();
        // ALU entries 10..13 pushed on four consecutive edges, one write per cycle afterwards.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive_alu(5'(10 + i), 32'hA0 + 32'(i));
                #1;
                total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready[%0d] got %b want 1", i, alu_ready); end
            end else begin
                idle_inputs();
            end
            @(negedge clk);
            if (i == 0 || i == 5) begin
                total++; if (wr_flag !== 1'b0) begin bad++; $display("[TB] FAIL b2b_flag[%0d] got %b want 0", i, wr_flag); end
            end else begin
                total++; if (wr_flag !== 1'b1 || rd_addr !== 5'(9 + i) || rd_data !== 32'h9F + 32'(i)) begin bad++; $display("[TB] FAIL b2b_write[%0d] got flag=%b addr=%0d data=%h want 1/%0d/%h", i, wr_flag, rd_addr, rd_data, 9 + i, 32'h9F + 32'(i)); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy got %b want 0", busy); end
    endtask

    task automatic test_one_free_slot();
        logic [4:0] exp_addr [6];
        exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd3;
        exp_addr[3] = 5'd4; exp_addr[4] = 5'd5; exp_addr[5] = 5'd6;
        drive_alu(5'd1, 32'h101);
        drive_load(5'd2, 32'h102);
        @(negedge clk);
        drive_alu(5'd3, 32'h103);
        drive_load(5'd4, 32'h104);
        #1;
        total++; if (load_ready !== 1'b1) begin bad++; $display("[TB] FAIL slot_ready_c2 got load=%b want 1", load_ready); end
        @(negedge clk);
        drive_alu(5'd5, 32'h105);
        drive_load(5'd6, 32'h106);
        #1;
        total++; if (alu_ready !== 1'b1 || load_ready !== 1'b0) begin bad++; $display("[TB] FAIL slot_ready_c3 got alu=%b load=%b want 1/0", alu_ready, load_ready); end
        total++; if (wr_flag !== 1'b1 || rd_addr !== exp_addr[0]) begin bad++; $display("[TB] FAIL slot_order[0] got flag=%b addr=%0d want 1/%0d", wr_flag, rd_addr, exp_addr[0]); end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        total++; if (load_ready !== 1'b1) begin bad++; $display("[TB] FAIL slot_load_retry got %b want 1", load_ready); end
        total++; if (wr_flag !== 1'b1 || rd_addr !== exp_addr[1]) begin bad++; $display("[TB] FAIL slot_order[1] got flag=%b addr=%0d want 1/%0d", wr_flag, rd_addr, exp_addr[1]); end
        @(negedge clk);
        idle_inputs();
        for (int i = 2; i < 6; i++) begin
            total++; if (wr_flag !== 1'b1 || rd_addr !== exp_addr[i] || rd_data !== 32'h100 + 32'(exp_addr[i])) begin bad++; $display("[TB] FAIL slot_order[%0d] got flag=%b addr=%0d data=%h want 1/%0d", i, wr_flag, rd_addr, rd_data, exp_addr[i]); end
            @(negedge clk);
        end
        total++; if (wr_flag !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL slot_idle got flag=%b busy=%b want 0/0", wr_flag, busy); end
    endtask

    task automatic test_reg_zero();
        drive_alu(5'd0, 32'h55);
        drive_load(5'd0, 32'h66);
        #1;
        total++; if (alu_ready !== 1'b1 || load_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_ready got alu=%b load=%b want 1/1", alu_ready, load_ready); end
        @(negedge clk);
        idle_inputs();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy got %b want 0", busy); end
        @(negedge clk);
        total++; if (wr_flag !== 1'b0) begin bad++; $display("[TB] FAIL zero_write got flag=%b want 0", wr_flag); end
    endtask

    task automatic test_forwarding();
        logic        exp_hit;
        logic [31:0] exp_b;
`ifdef WB_FORWARD_EN
        exp_hit = 1'b1;
        exp_b   = 32'hB;
`else
        exp_hit = 1'b0;
        exp_b   = 32'h0;
`endif
        drive_alu(5'd7, 32'hA);
        drive_load(5'd7, 32'hB);
        @(negedge clk);
        idle_inputs();
        rs1_addr = 5'd7;
        rs2_addr = 5'd0;
        #1;
        total++; if (rs1_hit !== exp_hit || rs1_data !== exp_b) begin bad++; $display("[TB] FAIL fwd_queue_newest got hit=%b data=%h want %b/%h", rs1_hit, rs1_data, exp_hit, exp_b); end
        total++; if (rs2_hit !== 1'b0 || rs2_data !== 32'h0) begin bad++; $display("[TB] FAIL fwd_addr0 got hit=%b data=%h want 0/0", rs2_hit, rs2_data); end
        @(negedge clk);
        rs2_addr = 5'd9;
        #1;
        total++; if (rs1_hit !== exp_hit || rs1_data !== exp_b) begin bad++; $display("[TB] FAIL fwd_over_outreg got hit=%b data=%h want %b/%h", rs1_hit, rs1_data, exp_hit, exp_b); end
        total++; if (rs2_hit !== 1'b0 || rs2_data !== 32'h0) begin bad++; $display("[TB] FAIL fwd_miss got hit=%b data=%h want 0/0", rs2_hit, rs2_data); end
        @(negedge clk);
        rs2_addr = 5'd7;
        #1;
        total++; if (rs2_hit !== exp_hit || rs2_data !== exp_b) begin bad++; $display("[TB] FAIL fwd_outreg got hit=%b data=%h want %b/%h", rs2_hit, rs2_data, exp_hit, exp_b); end
        @(negedge clk);
        #1;
        total++; if (rs1_hit !== 1'b0 || rs2_hit !== 1'b0 || rs1_data !== 32'h0) begin bad++; $display("[TB] FAIL fwd_drained got hit1=%b hit2=%b data1=%h want 0/0/0", rs1_hit, rs2_hit, rs1_data); end
        rs1_addr = '0;
        rs2_addr = '0;
    endtask

    task automatic test_reset_mid_drain();
        drive_alu(5'd8, 32'h808);
        drive_load(5'd9, 32'h909);
        @(negedge clk);
        drive_alu(5'd10, 32'hA0A);
        drive_load(5'd11, 32'hB0B);
        @(negedge clk);
        idle_inputs();
        total++; if (wr_flag !== 1'b1 || rd_addr !== 5'd8 || busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_drain_pre got flag=%b addr=%0d busy=%b want 1/8/1", wr_flag, rd_addr, busy); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (wr_flag !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'h0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL async_reset got flag=%b addr=%0d data=%h busy=%b want 0/0/0/0", wr_flag, rd_addr, rd_data, busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (wr_flag !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset[%0d] got flag=%b busy=%b want 0/0", i, wr_flag, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_dual_push();
        test_back_to_back();
        test_one_free_slot();
        test_reg_zero();
        test_forwarding();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side producer for the register file.
- Collects destination-register results from the ALU path and the load path and buffers them in order in a small FIFO.
- Drains at most one register write per cycle onto the register file's write port (Reg_Write_flag / RD_Addr / RD_Data).
- Offers a forwarding lookup so decode can read values still pending in the queue.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- ADDR_W, 5, register address width (32 architectural registers).
- DATA_W, 32, register data width.

Ports:
- Clk_In  input  1  clock
- Rst_In  input  1  asynchronous active-high reset
- ALU_Valid_In  input  1  ALU result offered
- ALU_Ready_Out  output  1  ALU result accepted this edge when Valid and Ready both high
- ALU_RD_Addr_In  input  ADDR_W  ALU destination register
- ALU_RD_Data_In  input  DATA_W  ALU result
- Load_Valid_In  input  1  load result offered
- Load_Ready_Out  output  1  load result accepted this edge when Valid and Ready both high
- Load_RD_Addr_In  input  ADDR_W  load destination register
- Load_RD_Data_In  input  DATA_W  load data
- Reg_Write_flag_Out  output  1  register file write enable, one-cycle pulse per write
- RD_Addr_Out  output  ADDR_W  register file write address
- RD_Data_Out  output  DATA_W  register file write data
- RS1_Addr_In  input  ADDR_W  forwarding lookup address 1
- RS2_Addr_In  input  ADDR_W  forwarding lookup address 2
- RS1_Hit_Out  output  1  pending write to RS1 exists
- RS1_Data_Out  output  DATA_W  newest pending value for RS1
- RS2_Hit_Out  output  1  pending write to RS2 exists
- RS2_Data_Out  output  DATA_W  newest pending value for RS2
- Busy_Out  output  1  queue non-empty or write in flight

Behaviour:
- Reset (asynchronous, Rst_In high):
  - Count, read pointer and write pointer go to 0.
  - Reg_Write_flag_Out, RD_Addr_Out, RD_Data_Out all go to 0.
  - Busy_Out goes to 0.
  - Entries assert mid-drain are discarded; no write pulse appears after reset.
- Ready is computed from registered count only; a pop in the same cycle does not raise ready.
  - ALU_Ready_Out = (count < DEPTH).
  - Load_Ready_Out = (count + (ALU_Valid_In & ALU_Ready_Out) < DEPTH).
- Push order when both sources are accepted on the same edge:
  - ALU entry takes the lower slot (older), load entry the next slot.
  - One free slot: ALU is accepted, load is held (Load_Ready_Out low).
- Destination register 0:
  - A handshake to register 0 completes normally, but nothing is stored and count does not change.
  - Such an entry never produces a write and never produces a hit.
- Drain:
  - On each edge with count > 0 (before this edge's pushes), the head entry is loaded into RD_Addr_Out / RD_Data_Out and Reg_Write_flag_Out is set to 1; the read pointer advances.
  - Otherwise Reg_Write_flag_Out is 0 and RD_Addr_Out / RD_Data_Out hold their last value.
- Latency: an entry accepted on edge N into an empty queue drives the write outputs after edge N+1. Steady-state throughput is one write per cycle.
- Simultaneous push and pop: count' = count + pushes − pop. The full queue stays full when one entry is pushed and one popped.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH; the queue never overflows or underflows by construction.
- Forwarding lookup (combinational):
  - Searches all valid queue entries plus the output register while Reg_Write_flag_Out is 1.
  - Newest match wins: youngest queue entry first, output register last.
  - Address 0 never hits.
  - With no match, Hit = 0 and Data = 0.
- Busy_Out = (count != 0) | Reg_Write_flag_Out.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: lookup logic present as described above.
- Undefined: lookup logic omitted; RS1_Hit_Out, RS2_Hit_Out, RS1_Data_Out, RS2_Data_Out tied to 0. Ports remain present so the interface is unchanged; decode must then stall while Busy_Out is high.

Test Plan:
- Reset with ALU push {addr 5, 0xDEADBEEF} on the first active edge -> after the next edge: Reg_Write_flag_Out=1, RD_Addr_Out=5, RD_Data_Out=0xDEADBEEF; flag is 0 on the following cycle.
- ALU {3, 0x11} and Load {4, 0x22} valid on the same edge, empty queue -> writes emitted in order addr 3 then addr 4 on consecutive cycles.
- Hold downstream full: DEPTH=4, push 4 ALU entries with no drain gap -> ALU_Ready_Out=0 only when count=4; no entry lost; 4 sequential write pulses in push order.
- Both sources valid with count=3 -> ALU accepted, Load_Ready_Out=0; load accepted the next cycle; total write order preserved.
- Queue holds {7, 0xA} then {7, 0xB}; RS1_Addr_In=7 -> RS1_Hit_Out=1, RS1_Data_Out=0xB; RS2_Addr_In=0 -> RS2_Hit_Out=0.
- Assert Rst_In asynchronously with 3 entries queued mid-drain -> outputs go to 0 immediately; no further write pulses; Busy_Out=0.
